// File: rtl/reg_bank.sv
// Register bank: DEPTH x DATA_W words, 3 async reads, 1 write, debug tap, sequential clear sweep.
// Latency: state updates on the falling clk edge, reads are combinational; a sweep takes DEPTH edges after the request edge.
// Backpressure: none; writes arriving during or with a clear are dropped and flagged sticky on w_drop. REG_BANK_BYPASS_EN adds write-first forwarding.
module reg_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r_add1,
    input  logic [ADDR_W-1:0] r_add2,
    input  logic [ADDR_W-1:0] rsel_addr,
    input  logic [ADDR_W-1:0] w_add,
    input  logic              w_flag,
    input  logic [DATA_W-1:0] w_data,
    input  logic              clr_req,
    output logic [DATA_W-1:0] r_data1,
    output logic [DATA_W-1:0] r_data2,
    output logic [DATA_W-1:0] rsel_data,
    output logic              debug,
    output logic              busy,
    output logic              w_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic                w_drop_q, w_drop_d;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mem_d    = mem_q;
        w_drop_d = w_drop_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    if (w_flag) w_drop_d = 1'b1;
                end else if (w_flag) begin
                    mem_d[w_add] = w_data;
                end
            end
            CLEAR: begin
                mem_d[ptr_q] = '0;
                ptr_d        = ptr_q + ADDR_W'(1);
                if (w_flag) w_drop_d = 1'b1;
                // Last entry swept: pointer wraps to 0 through the increment.
                if (ptr_q == {ADDR_W{1'b1}}) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            w_drop_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            w_drop_q <= w_drop_d;
            mem_q    <= mem_d;
        end
    end

    assign busy   = (state_q == CLEAR);
    assign w_drop = w_drop_q;

`ifdef REG_BANK_BYPASS_EN
    // Only a write that will actually land in storage this edge is forwarded.
    logic fwd;
    assign fwd       = w_flag && (state_q == IDLE) && !clr_req;
    assign r_data1   = (fwd && (r_add1 == w_add))    ? w_data : mem_q[r_add1];
    assign r_data2   = (fwd && (r_add2 == w_add))    ? w_data : mem_q[r_add2];
    assign rsel_data = (fwd && (rsel_addr == w_add)) ? w_data : mem_q[rsel_addr];
    assign debug     = (fwd && (w_add == '0))        ? w_data[0] : mem_q[0][0];
`else
    assign r_data1   = mem_q[r_add1];
    assign r_data2   = mem_q[r_add2];
    assign rsel_data = mem_q[rsel_addr];
    assign debug     = mem_q[0][0];
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank; expected outputs are queued by the stimulus and compared by a monitor.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  r_add1, r_add2, rsel_addr, w_add;
    logic        w_flag, clr_req;
    logic [15:0] w_data;
    logic [15:0] r_data1, r_data2, rsel_data;
    logic        debug, busy, w_drop;

    int checks = 0;
    int failures = 0;

    logic [50:0] exp_q[$];
    string       nm_q[$];

    reg_bank #(.DATA_W(16), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .r_add1(r_add1), .r_add2(r_add2), .rsel_addr(rsel_addr),
        .w_add(w_add), .w_flag(w_flag), .w_data(w_data), .clr_req(clr_req),
        .r_data1(r_data1), .r_data2(r_data2), .rsel_data(rsel_data),
        .debug(debug), .busy(busy), .w_drop(w_drop)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are sampled on the rising edge, half a cycle away from the active falling edge.
    logic [50:0] m_exp, m_got;
    string       m_nm;
    always @(posedge clk) begin
        while (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            m_nm  = nm_q.pop_front();
            m_got = {r_data1, r_data2, rsel_data, debug, busy, w_drop};
            checks++;
            if (m_got !== m_exp) begin
                failures++;
                $display("FAIL %s got r1=%h r2=%h rs=%h dbg=%b busy=%b drop=%b exp r1=%h r2=%h rs=%h dbg=%b busy=%b drop=%b",
                         m_nm, m_got[50:35], m_got[34:19], m_got[18:3], m_got[2], m_got[1], m_got[0],
                         m_exp[50:35], m_exp[34:19], m_exp[18:3], m_exp[2], m_exp[1], m_exp[0]);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic [15:0] e1, input logic [15:0] e2,
                            input logic [15:0] es, input logic ed, input logic eb, input logic ew);
        exp_q.push_back({e1, e2, es, ed, eb, ew});
        nm_q.push_back(nm);
    endtask

    task automatic set_rd(input logic [1:0] a1, input logic [1:0] a2, input logic [1:0] as);
        r_add1 = a1; r_add2 = a2; rsel_addr = as;
    endtask

    task automatic set_wr(input logic f, input logic [1:0] a, input logic [15:0] d);
        w_flag = f; w_add = a; w_data = d;
    endtask

    initial begin
        reset = 1'b1; clr_req = 1'b0;
        set_wr(1'b0, 2'd0, 16'h0);
        set_rd(2'd0, 2'd1, 2'd2);
        tick();
        reset = 1'b0;
        expect_o("reset", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

        // Basic writes, including same-cycle read of the address being written.
        set_wr(1'b1, 2'd2, 16'hBEEF);
        set_rd(2'd2, 2'd0, 2'd3);
        expect_o("wr_pre", BYP ? 16'hBEEF : 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_wr(1'b1, 2'd0, 16'h0001);
        expect_o("wr2_pre", 16'hBEEF, BYP ? 16'h0001 : 16'h0, 16'h0, BYP, 1'b0, 1'b0);
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        expect_o("wr_post", 16'hBEEF, 16'h0001, 16'h0, 1'b1, 1'b0, 1'b0);

        // Fill, then sweep; entry k reads 0 only after edge N+1+k.
        for (int k = 0; k < 4; k++) begin
            tick();
            set_wr(1'b1, 2'(k), 16'h1111 * 16'(k + 1));
        end
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        set_rd(2'd0, 2'd1, 2'd3);
        clr_req = 1'b1;
        expect_o("fill", 16'h1111, 16'h2222, 16'h4444, 1'b1, 1'b0, 1'b0);
        tick();
        clr_req = 1'b0;
        expect_o("swp_n", 16'h1111, 16'h2222, 16'h4444, 1'b1, 1'b1, 1'b0);
        tick();
        expect_o("swp_n1", 16'h0, 16'h2222, 16'h4444, 1'b0, 1'b1, 1'b0);
        tick();
        // Write during CLEAR must be dropped; a repeated clr_req must not extend the sweep.
        set_wr(1'b1, 2'd3, 16'hAAAA);
        clr_req = 1'b1;
        expect_o("swp_n2", 16'h0, 16'h0, 16'h4444, 1'b0, 1'b1, 1'b0);
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        clr_req = 1'b0;
        set_rd(2'd2, 2'd1, 2'd3);
        expect_o("swp_n3", 16'h0, 16'h0, 16'h4444, 1'b0, 1'b1, 1'b1);
        tick();
        expect_o("swp_n4", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_o("no_extend", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        // Reset clears the sticky drop flag.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_rd(2'd0, 2'd1, 2'd3);
        expect_o("rst2", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        set_wr(1'b1, 2'd1, 16'h7777);
        tick();
        // clr_req and w_flag together in IDLE: clear wins.
        set_wr(1'b1, 2'd1, 16'h5555);
        clr_req = 1'b1;
        expect_o("cw_pre", 16'h0, 16'h7777, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        clr_req = 1'b0;
        expect_o("cw_n", 16'h0, 16'h7777, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        expect_o("cw_n1", 16'h0, 16'h7777, 16'h0, 1'b0, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        expect_o("cw_n2", 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);

        // Reset mid-sweep, then a write on the following edge.
        tick();
        reset = 1'b0;
        set_wr(1'b1, 2'd3, 16'h9999);
        set_rd(2'd3, 2'd1, 2'd3);
        expect_o("rst_mid", BYP ? 16'h9999 : 16'h0, 16'h0, BYP ? 16'h9999 : 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        expect_o("post_rst_wr", 16'h9999, 16'h0, 16'h9999, 1'b0, 1'b0, 1'b0);

        // Same-cycle read of a write target: forwarded only with bypass.
        set_wr(1'b1, 2'd1, 16'hC0DE);
        expect_o("byp_pre", 16'h9999, BYP ? 16'hC0DE : 16'h0, 16'h9999, 1'b0, 1'b0, 1'b0);
        tick();
        set_wr(1'b0, 2'd0, 16'h0);
        expect_o("byp_post", 16'h9999, 16'hC0DE, 16'h9999, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
